kmp_matcher: RTL and testbench

//  KMP search engine directly downstream of the string/pattern buffer plus failure-function stage.

---
 rtl/kmp_matcher_pkg.sv | 23 ++
 rtl/sme_char_sel.sv | 21 ++
 rtl/kmp_matcher.sv | 147 ++++++++++++++
 tb/tb_kmp_matcher.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kmp_matcher_pkg.sv
// Shared sizing and FSM encodings for the KMP search stage and the SME top level.
package kmp_matcher_pkg;

    localparam int unsigned BYTE        = 8;
    localparam int unsigned MAX_STRING  = 32;
    localparam int unsigned MAX_PATTERN = 8;
    localparam int unsigned MAX_STR_ADD = 5;
    localparam int unsigned MAX_PAT_ADD = 3;

    localparam int unsigned STR_AW = MAX_STR_ADD;
    localparam int unsigned PAT_AW = MAX_PAT_ADD;
    localparam int unsigned STR_W  = MAX_STRING * BYTE;
    localparam int unsigned PAT_W  = MAX_PATTERN * BYTE;
    localparam int unsigned FF_W   = MAX_PATTERN * PAT_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } kmp_state_e;

endpackage

// File: rtl/sme_char_sel.sv
// Combinational element extractor: picks element idx (W bits wide) out of a packed vector of N.
module sme_char_sel #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 32,
    parameter int unsigned IW = 5
) (
    input  logic [W*N-1:0] vec,
    input  logic [IW-1:0]  idx,
    output logic [W-1:0]   elem_c
);

    localparam int unsigned SW = $clog2(W * N);

    logic [SW-1:0] base_c;

    always_comb begin
        base_c = SW'(idx) * SW'(W);
        elem_c = vec[base_c +: W];
    end

endmodule

// File: rtl/kmp_matcher.sv
// KMP first-occurrence search over a snapshot of the string, pattern and failure table.
module kmp_matcher
    import kmp_matcher_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [STR_W-1:0]  str_reg,
    input  logic [PAT_W-1:0]  pat_reg,
    input  logic [STR_AW-1:0] str_last_idx,
    input  logic [PAT_AW-1:0] pat_last_idx,
    input  logic [FF_W-1:0]   ff_result,
    output logic              busy,
    output logic              match,
    output logic [STR_AW-1:0] match_index,
    output logic              o_valid
);

    kmp_state_e        state_q, state_d;
    logic              valid_q;
    logic [STR_W-1:0]  str_q;
    logic [PAT_W-1:0]  pat_q;
    logic [FF_W-1:0]   ff_q;
    logic [STR_AW-1:0] str_last_q;
    logic [PAT_AW-1:0] pat_last_q;
    logic [STR_AW-1:0] i_q, i_d;
    logic [PAT_AW-1:0] q_q, q_d;

    logic              busy_d, match_d, o_valid_d;
    logic [STR_AW-1:0] index_d;

    logic              start_c;
    logic [BYTE-1:0]   str_ch_c, pat_ch_c;
    logic [PAT_AW-1:0] q_prev_c, ff_entry_c;
    logic [STR_AW-1:0] rem_str_c, rem_pat_c;

    sme_char_sel #(.W(BYTE), .N(MAX_STRING), .IW(STR_AW)) u_str_sel (
        .vec(str_q), .idx(i_q), .elem_c(str_ch_c)
    );
    sme_char_sel #(.W(BYTE), .N(MAX_PATTERN), .IW(PAT_AW)) u_pat_sel (
        .vec(pat_q), .idx(q_q), .elem_c(pat_ch_c)
    );
    sme_char_sel #(.W(PAT_AW), .N(MAX_PATTERN), .IW(PAT_AW)) u_ff_sel (
        .vec(ff_q), .idx(q_prev_c), .elem_c(ff_entry_c)
    );

    assign start_c   = i_valid & ~valid_q;
    assign q_prev_c  = q_q - PAT_AW'(1);
    // i never passes str_last and q never passes pat_last, so both differences are non-negative
    assign rem_str_c = str_last_q - i_q;
    assign rem_pat_c = STR_AW'(pat_last_q - q_q);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        q_d       = q_q;
        busy_d    = busy;
        match_d   = match;
        index_d   = match_index;
        o_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                i_d     = '0;
                q_d     = '0;
                match_d = 1'b0;
                index_d = '0;
                busy_d  = 1'b1;
                state_d = (STR_AW'(pat_last_idx) > str_last_idx) ? DONE : SCAN;
            end
            SCAN: begin
                if (rem_str_c < rem_pat_c) begin
                    state_d = DONE;
                    match_d = 1'b0;
                end else if (str_ch_c == pat_ch_c) begin
                    if (q_q == pat_last_q) begin
                        match_d = 1'b1;
                        index_d = i_q - STR_AW'(pat_last_q);
                        state_d = DONE;
                    end else if (i_q == str_last_q) begin
                        state_d = DONE;
                    end else begin
                        q_d = q_q + PAT_AW'(1);
                        i_d = i_q + STR_AW'(1);
                    end
                end else if (q_q != '0) begin
                    q_d = ff_entry_c;
                end else if (i_q == str_last_q) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + STR_AW'(1);
                end
            end
            DONE: begin
                o_valid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            busy        <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            o_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= i_valid;
            i_q         <= i_d;
            q_q         <= q_d;
            busy        <= busy_d;
            match       <= match_d;
            match_index <= index_d;
            o_valid     <= o_valid_d;
        end
    end

    // Snapshot taken during LOAD; upstream may change freely afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_q      <= '0;
            pat_q      <= '0;
            ff_q       <= '0;
            str_last_q <= '0;
            pat_last_q <= '0;
        end else if (state_q == LOAD) begin
            str_q      <= str_reg;
            pat_q      <= pat_reg;
            ff_q       <= ff_result;
            str_last_q <= str_last_idx;
            pat_last_q <= pat_last_idx;
        end
    end

endmodule

// File: tb/tb_kmp_matcher.sv
// Self-checking bench for kmp_matcher against a brute-force first-occurrence search model.
module tb_kmp_matcher;
    import kmp_matcher_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid;
    logic [STR_W-1:0]  str_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [STR_AW-1:0] str_last_idx;
    logic [PAT_AW-1:0] pat_last_idx;
    logic [FF_W-1:0]   ff_result;
    logic              busy, match, o_valid;
    logic [STR_AW-1:0] match_index;

    int checks = 0;
    int errors = 0;

    byte unsigned ts[MAX_STRING];
    byte unsigned tp[MAX_PATTERN];
    int tslen, tplen;

    kmp_matcher dut (
        .clk(clk), .reset(reset), .i_valid(i_valid),
        .str_reg(str_reg), .pat_reg(pat_reg),
        .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
        .ff_result(ff_result), .busy(busy), .match(match),
        .match_index(match_index), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    // Longest proper border of tp[0..k], by direct comparison of prefix and suffix
    function automatic int border_len(int k);
        for (int b = k; b > 0; b--) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < b; j++)
                if (tp[j] != tp[k - b + 1 + j]) ok = 1'b0;
            if (ok) return b;
        end
        return 0;
    endfunction

    function automatic void ref_search(output bit m, output int idx);
        m = 1'b0;
        idx = 0;
        for (int st = 0; st + tplen <= tslen; st++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < tplen; j++)
                if (ts[st + j] != tp[j]) ok = 1'b0;
            if (ok && !m) begin
                m = 1'b1;
                idx = st;
            end
        end
    endfunction

    // Characters past the last index are random so the DUT must ignore them
    task automatic drive_job();
        for (int k = 0; k < MAX_STRING; k++)
            str_reg[k*BYTE +: BYTE] = (k < tslen) ? ts[k] : 8'($urandom);
        for (int k = 0; k < MAX_PATTERN; k++) begin
            pat_reg[k*BYTE +: BYTE]     = (k < tplen) ? tp[k] : 8'($urandom);
            ff_result[k*PAT_AW +: PAT_AW] = (k < tplen) ? 3'(border_len(k)) : 3'($urandom);
        end
        str_last_idx = 5'(tslen - 1);
        pat_last_idx = 3'(tplen - 1);
    endtask

    task automatic set_text(input string s, input string p);
        tslen = s.len();
        tplen = p.len();
        for (int k = 0; k < tslen; k++) ts[k] = s[k];
        for (int k = 0; k < tplen; k++) tp[k] = p[k];
        drive_job();
    endtask

    // Raises i_valid, captures the first o_valid pulse, keeps watching for extra pulses
    task automatic run_job(input int tail_cycles, output bit m, output int idx, output int lat,
                           output bit to, output int pulses, output bit busy_before, output bit busy_at);
        bit prev_busy;
        int tail;
        @(negedge clk);
        i_valid = 1'b1;
        to = 1'b1; pulses = 0; lat = 0; m = 1'b0; idx = 0;
        busy_before = 1'b0; busy_at = 1'b0; tail = 0;
        prev_busy = busy;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (o_valid) begin
                if (to) begin
                    to = 1'b0;
                    lat = c - 1;
                    m = match;
                    idx = int'(match_index);
                    busy_before = prev_busy;
                    busy_at = busy;
                    tail = c + tail_cycles;
                end
                pulses++;
            end
            prev_busy = busy;
            if (!to && c >= tail) break;
        end
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; i_valid = 1'b0;
        str_reg = '0; pat_reg = '0; ff_result = '0; str_last_idx = '0; pat_last_idx = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b expected 0", match); end
        checks++; if (match_index !== 5'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", match_index); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b expected 0", o_valid); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit m, to, bb, ba; int idx, lat, p;
        set_text("ABABAC", "ABAC");
        run_job(5, m, idx, lat, to, p, bb, ba);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: no o_valid"); end
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL basic_match: got %b expected 1", m); end
        checks++; if (idx != 2) begin errors++; $display("FAIL basic_index: got %0d expected 2", idx); end
        checks++; if (p != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", p); end
    endtask

    task automatic test_no_match();
        bit m, to, bb, ba; int idx, lat, p;
        set_text("AAAA", "AB");
        run_job(5, m, idx, lat, to, p, bb, ba);
        checks++; if (to) begin errors++; $display("FAIL nomatch_timeout: no o_valid"); end
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL nomatch_match: got %b expected 0", m); end
        checks++; if (idx != 0) begin errors++; $display("FAIL nomatch_index: got %0d expected 0", idx); end
        checks++; if (lat > 11) begin errors++; $display("FAIL nomatch_latency: got %0d expected <= 11", lat); end
        checks++; if (bb !== 1'b1 || ba !== 1'b0) begin errors++; $display("FAIL nomatch_busy_edge: got before=%b at=%b expected 1/0", bb, ba); end
    endtask

    task automatic test_single_char();
        bit m, to, bb, ba; int idx, lat, p;
        set_text("XYZQ", "Q");
        run_job(3, m, idx, lat, to, p, bb, ba);
        checks++; if (to || m !== 1'b1) begin errors++; $display("FAIL single_match: got %b timeout=%b expected 1", m, to); end
        checks++; if (idx != 3) begin errors++; $display("FAIL single_index: got %0d expected 3", idx); end
    endtask

    task automatic test_pat_longer();
        bit m, to, bb, ba; int idx, lat, p;
        set_text("AB", "ABAB");
        run_job(3, m, idx, lat, to, p, bb, ba);
        checks++; if (to || m !== 1'b0) begin errors++; $display("FAIL longer_match: got %b timeout=%b expected 0", m, to); end
        checks++; if (lat != 2) begin errors++; $display("FAIL longer_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_hold_level();
        bit m, to, bb, ba; int idx, lat, p;
        set_text("ABABAC", "ABAC");
        run_job(50, m, idx, lat, to, p, bb, ba);
        checks++; if (to || p != 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", p); end
        set_text("CABAB", "ABAB");
        run_job(5, m, idx, lat, to, p, bb, ba);
        checks++; if (to || m !== 1'b1 || p != 1) begin errors++; $display("FAIL hold_second_match: got %b pulses=%0d expected 1/1", m, p); end
        checks++; if (idx != 1) begin errors++; $display("FAIL hold_second_index: got %0d expected 1", idx); end
    endtask

    task automatic test_reset_mid_scan();
        bit m, to, bb, ba, seen; int idx, lat, p;
        set_text("ABABAC", "ABAC");
        @(negedge clk);
        i_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy_before: got %b expected 1", busy); end
        #1 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL midscan_reset_ctrl: got busy=%b o_valid=%b expected 0/0", busy, o_valid); end
        checks++; if (match !== 1'b0 || match_index !== 5'd0) begin errors++; $display("FAIL midscan_reset_result: got %b/%0d expected 0/0", match, match_index); end
        i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (o_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midscan_spurious: got o_valid=1 expected 0"); end
        run_job(3, m, idx, lat, to, p, bb, ba);
        checks++; if (to || m !== 1'b1 || idx != 2) begin errors++; $display("FAIL midscan_rerun: got %b/%0d expected 1/2", m, idx); end
    endtask

    task automatic test_snapshot();
        bit m, got; int idx;
        set_text("ABABAC", "ABAC");
        @(negedge clk);
        i_valid = 1'b1;
        got = 1'b0; m = 1'b0; idx = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (o_valid) begin got = 1'b1; m = match; idx = int'(match_index); end
            if (c >= 2) begin
                for (int k = 0; k < MAX_STRING; k++) str_reg[k*BYTE +: BYTE] = 8'($urandom);
                pat_reg = {$urandom, $urandom};
                ff_result = 24'($urandom);
                str_last_idx = 5'($urandom);
                pat_last_idx = 3'($urandom);
            end
        end
        i_valid = 1'b0;
        @(negedge clk);
        checks++; if (!got || m !== 1'b1 || idx != 2) begin errors++; $display("FAIL snapshot: got %b/%0d valid=%b expected 1/2", m, idx, got); end
    endtask

    task automatic test_random();
        bit m, to, bb, ba, em; int idx, lat, p, eidx, alpha;
        for (int it = 0; it < 40; it++) begin
            tslen = $urandom_range(1, MAX_STRING);
            tplen = $urandom_range(1, MAX_PATTERN);
            alpha = $urandom_range(2, 3);
            for (int k = 0; k < tslen; k++) ts[k] = 8'(65 + $urandom_range(0, alpha - 1));
            for (int k = 0; k < tplen; k++) tp[k] = 8'(65 + $urandom_range(0, alpha - 1));
            if (tplen <= tslen && $urandom_range(0, 1) == 1) begin
                int pos;
                pos = $urandom_range(0, tslen - tplen);
                for (int k = 0; k < tplen; k++) ts[pos + k] = tp[k];
            end
            drive_job();
            ref_search(em, eidx);
            run_job(2, m, idx, lat, to, p, bb, ba);
            checks++;
            if (to || m !== em || idx != eidx) begin
                errors++;
                $display("FAIL random_%0d: got match=%b idx=%0d expected match=%b idx=%0d (slen=%0d plen=%0d)", it, m, idx, em, eidx, tslen, tplen);
            end
            checks++;
            if (lat > 2 * tslen + 3) begin
                errors++;
                $display("FAIL random_latency_%0d: got %0d expected <= %0d", it, lat, 2 * tslen + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_match();
        test_single_char();
        test_pat_longer();
        test_hold_level();
        test_reset_mid_scan();
        test_snapshot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
